// File: rtl/epochtv1_vram_arb.sv
`default_nettype none
// ============================================================================
// epochtv1_vram_arb : CPU-side VRAM access arbiter for the TV-1 video chip.
//                     Video fetch always wins; the CPU is stalled via WAIT.
// Revision: 1.0
// ============================================================================
module epochtv1_vram_arb #(
  parameter int STARVE_LIMIT = 8
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        CE,
  input  logic [12:0] A,
  input  logic [7:0]  DB_I,
  output logic [7:0]  DB_O,
  output logic        DB_OE,
  input  logic        RDB,
  input  logic        WRB,
  input  logic        CSB,
  output logic        WAIT,
  input  logic        VID_REQ,
  input  logic [11:0] VID_A,
  output logic [15:0] VID_D,
  output logic        VID_VALID,
  output logic [11:0] VAA,
  input  logic [7:0]  VAD_I,
  output logic [7:0]  VAD_O,
  output logic        nVARD,
  output logic        nVAWR,
  output logic [11:0] VBA,
  input  logic [7:0]  VBD_I,
  output logic [7:0]  VBD_O,
  output logic        nVBRD,
  output logic        nVBWR,
  output logic        STARVED
);

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PEND  = 2'd1,
    S_RDATA = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nx;

  logic        cpu_act;
  logic        prev_act;
  logic        new_req;
  logic        grant;
  logic        deny;

  logic [12:0] lat_addr;
  logic [7:0]  lat_data;
  logic        lat_wr;

  logic [7:0]  starve_cnt;
  logic [7:0]  cnt_inc;
  logic        starved_r;
  logic [7:0]  db_o_r;
  logic        vid_valid_r;
  logic [11:0] addr_q;
  logic [11:0] vaddr;

  always_comb begin
    cpu_act = ~CSB & (RDB ^ WRB);
    new_req = cpu_act & ~prev_act;
    grant   = (state == S_PEND) & cpu_act & ~VID_REQ & ~RESET;
    deny    = (state == S_PEND) & cpu_act & VID_REQ;
    cnt_inc = (starve_cnt == 8'hFF) ? 8'hFF : starve_cnt + 8'd1;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (new_req) state_nx = S_PEND;
      S_PEND: begin
        if (!cpu_act)      state_nx = S_IDLE;
        else if (!VID_REQ) state_nx = lat_wr ? S_HOLD : S_RDATA;
      end
      S_RDATA: state_nx = S_HOLD;
      S_HOLD:  if (!cpu_act) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= S_IDLE;
    end else if (CE) begin
      state <= state_nx;
    end
  end

  // prev_act resets high so a strobe held through reset must release first
  always_ff @(posedge CLK) begin
    if (RESET) begin
      prev_act    <= 1'b1;
      vid_valid_r <= 1'b0;
    end else if (CE) begin
      prev_act    <= cpu_act;
      vid_valid_r <= VID_REQ;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      lat_addr <= 13'd0;
      lat_data <= 8'd0;
      lat_wr   <= 1'b0;
    end else if (CE && state == S_IDLE && new_req) begin
      lat_addr <= A;
      lat_data <= DB_I;
      lat_wr   <= ~WRB;
    end
  end

  // Any CE cycle that is not a denial breaks the consecutive-denial run
  always_ff @(posedge CLK) begin
    if (RESET) begin
      starve_cnt <= 8'd0;
      starved_r  <= 1'b0;
    end else if (CE) begin
      starve_cnt <= deny ? cnt_inc : 8'd0;
      if (deny && cnt_inc >= LIMIT) starved_r <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      db_o_r <= 8'd0;
    end else if (CE && state == S_RDATA) begin
      db_o_r <= lat_addr[0] ? VBD_I : VAD_I;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      addr_q <= 12'd0;
    end else if (CE) begin
      addr_q <= vaddr;
    end
  end

  always_comb begin
    vaddr = addr_q;
    nVARD = 1'b0;
    nVBRD = 1'b0;
    nVAWR = 1'b1;
    nVBWR = 1'b1;
    if (!RESET) begin
      if (VID_REQ) begin
        vaddr = VID_A;
      end else if (grant) begin
        vaddr = lat_addr[12:1];
        if (lat_wr) begin
          nVARD = 1'b1;
          nVBRD = 1'b1;
          nVAWR = lat_addr[0];
          nVBWR = ~lat_addr[0];
        end
      end
    end
  end

  assign VAA       = vaddr;
  assign VBA       = vaddr;
  assign VAD_O     = lat_data;
  assign VBD_O     = lat_data;

  assign WAIT      = ~RESET & ((state == S_PEND) | (state == S_RDATA) |
                               ((state == S_IDLE) & new_req));
  assign DB_OE     = ~RESET & ~CSB & ~RDB & (state == S_HOLD) & ~lat_wr;
  assign DB_O      = db_o_r;
  assign VID_VALID = vid_valid_r;
  assign VID_D     = vid_valid_r ? {VBD_I, VAD_I} : 16'h0000;
  assign STARVED   = starved_r;

endmodule
`default_nettype wire
